sram_controller: RTL and testbench

//  Sequences the MEM-stage memory access onto an external 16-bit asynchronous SRAM.

---
 rtl/mem_ctrl_pkg.sv | 15 +
 rtl/sram_phase_timer.sv | 17 +
 rtl/sram_controller.sv | 93 +++++++++
 tb/tb_sram_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: state encoding and shared constants for the SRAM memory controller
package mem_ctrl_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_LO = 3'd1;
  localparam logic [2:0] S_RD_HI = 3'd2;
  localparam logic [2:0] S_WR_LO = 3'd3;
  localparam logic [2:0] S_WR_HI = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
  localparam int SRAM_DQ_WIDTH = 16;

  function automatic logic is_phase(input logic [2:0] s);
    return s == S_RD_LO || s == S_RD_HI || s == S_WR_LO || s == S_WR_HI;
  endfunction
endpackage

// File: rtl/sram_phase_timer.sv
// sram_phase_timer: down-counter marking the final cycle of a WAIT_CYCLES-long SRAM phase
module sram_phase_timer #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic lastOut
);
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  logic [CW-1:0] r_cnt;
  // clear is held outside phases, so every phase starts from WAIT_CYCLES-1
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else      r_cnt <= clear ? CW'(WAIT_CYCLES - 1) : r_cnt - CW'(1);
  assign lastOut = r_cnt == '0;
endmodule

// File: rtl/sram_controller.sv
// sram_controller: runs each 32-bit MEM-stage access as two timed 16-bit phases
// on an asynchronous SRAM; readyOut low means the pipeline must freeze.
module sram_controller
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
  parameter int          SRAM_ADDR_WIDTH = 18,
  parameter int          WAIT_CYCLES     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdEnIn,
  input  logic                       wrEnIn,
  input  logic [31:0]                addressIn,
  input  logic [31:0]                writeDataIn,
  output logic [31:0]                readDataOut,
  output logic                       readyOut,
  output logic [SRAM_ADDR_WIDTH-1:0] sramAddrOut,
  output logic [SRAM_DQ_WIDTH-1:0]   sramDqOut,
  input  logic [SRAM_DQ_WIDTH-1:0]   sramDqIn,
  output logic                       sramDqOeOut,
  output logic                       sramWeNOut,
  output logic                       sramOeNOut,
  output logic                       sramCeNOut,
  output logic                       sramUbNOut,
  output logic                       sramLbNOut
);
  logic [2:0]               r_state;
  logic [31:0]              r_addr;
  logic [31:0]              r_data;
  logic [31:0]              r_rd_data;
  logic [SRAM_DQ_WIDTH-1:0] r_lo;
  logic [2:0]               w_next;
  logic                     w_last;
  logic                     w_rd_ph;
  logic                     w_wr_ph;
  logic                     w_phase;
  logic                     w_hi;
  logic                     w_accept;
  logic [31:0]              w_offset;
  logic                     w_unused;

  sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (~w_phase | w_last),
    .lastOut(w_last)
  );

  assign w_rd_ph  = r_state == S_RD_LO || r_state == S_RD_HI;
  assign w_wr_ph  = r_state == S_WR_LO || r_state == S_WR_HI;
  assign w_phase  = is_phase(r_state);
  assign w_hi     = r_state == S_RD_HI || r_state == S_WR_HI;
  assign w_accept = r_state == S_IDLE && (rdEnIn || wrEnIn);
  assign w_offset = r_addr - BASE_ADDR;
  assign w_unused = ^{w_offset[31:SRAM_ADDR_WIDTH+1], w_offset[1:0]};

  // read has priority when both enables are raised together
  always_comb
    w_next = r_state == S_IDLE  ? (rdEnIn ? S_RD_LO : wrEnIn ? S_WR_LO : S_IDLE) :
             r_state == S_DONE  ? S_IDLE :
             !w_last            ? r_state :
             r_state == S_RD_LO ? S_RD_HI :
             r_state == S_WR_LO ? S_WR_HI : S_DONE;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_data    <= '0;
      r_rd_data <= '0;
      r_lo      <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr <= addressIn;
        r_data <= writeDataIn;
      end
      if (r_state == S_RD_LO && w_last) r_lo <= sramDqIn;
      if (r_state == S_RD_HI && w_last) r_rd_data <= {sramDqIn, r_lo};
    end

  assign readDataOut = r_rd_data;
  assign readyOut    = r_state == S_IDLE ? ~(rdEnIn | wrEnIn) : r_state == S_DONE;
  assign sramAddrOut = w_phase ? {w_offset[SRAM_ADDR_WIDTH:2], w_hi} : '0;
  assign sramDqOut   = w_wr_ph ? (w_hi ? r_data[31:16] : r_data[15:0]) : '0;
  assign sramDqOeOut = w_wr_ph;
  assign sramWeNOut  = ~w_wr_ph;
  assign sramOeNOut  = ~w_rd_ph;
  assign sramCeNOut  = ~w_phase;
  assign sramUbNOut  = ~w_phase;
  assign sramLbNOut  = ~w_phase;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed accesses against a word-level model of the controller
module tb_sram_controller;
  localparam int W = 3;
  localparam logic [31:0] BASE = 32'd1024;
  logic clk = 0, rst = 0, rdEnIn = 0, wrEnIn = 0;
  logic [31:0] addressIn = 0, writeDataIn = 0, readDataOut;
  logic readyOut, sramDqOeOut, weN, oeN, ceN, ubN, lbN;
  logic [17:0] sramAddrOut;
  logic [15:0] sramDqOut, sramDqIn;
  logic [15:0] sram [0:262143];
  logic [31:0] mw [0:131071];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sram_controller #(.BASE_ADDR(BASE), .SRAM_ADDR_WIDTH(18), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .rdEnIn(rdEnIn), .wrEnIn(wrEnIn), .addressIn(addressIn),
    .writeDataIn(writeDataIn), .readDataOut(readDataOut), .readyOut(readyOut),
    .sramAddrOut(sramAddrOut), .sramDqOut(sramDqOut), .sramDqIn(sramDqIn),
    .sramDqOeOut(sramDqOeOut), .sramWeNOut(weN), .sramOeNOut(oeN), .sramCeNOut(ceN),
    .sramUbNOut(ubN), .sramLbNOut(lbN)
  );

  function automatic logic [15:0] hwdef(input int a);
    logic [31:0] v;
    v = a;
    return v[15:0] ^ 16'h5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  assign sramDqIn = sram[sramAddrOut];

  // asynchronous SRAM: halfword store on any clock while written
  initial begin
    for (int a = 0; a < 262144; a++) sram[a] = hwdef(a);
    forever begin
      @(posedge clk);
      if (!weN && !ceN) sram[sramAddrOut] <= sramDqOut;
    end
  end

  // word-level model: t counts cycles since the request cycle, -1 when idle
  initial begin
    int t;
    logic m_rd, lo, hi, ph;
    logic [31:0] m_off, m_dat, exp_rd;
    t = -1; m_rd = 0; m_off = 0; m_dat = 0; exp_rd = 0;
    for (int k = 0; k < 131072; k++) mw[k] = {hwdef(2 * k + 1), hwdef(2 * k)};
    forever begin
      @(negedge clk);
      if (!rst) begin
        t = -1;
        exp_rd = 0;
      end
      if (t < 0) begin
        chk("m_idle_ready", readyOut, !(rdEnIn || wrEnIn));
        chk("m_idle_addr", sramAddrOut, 0);
        chk("m_idle_dq", {sramDqOeOut, sramDqOut}, 0);
        chk("m_idle_strobes", {ceN, oeN, weN, ubN, lbN}, 5'h1f);
        chk("m_idle_rdata", readDataOut, exp_rd);
        if (rst && (rdEnIn || wrEnIn)) begin
          m_rd = rdEnIn;
          m_off = addressIn - BASE;
          m_dat = writeDataIn;
          t = 1;
          if (!m_rd) mw[m_off[18:2]] = m_dat;
        end
      end else begin
        lo = t >= 1 && t <= W;
        hi = t > W && t <= 2 * W;
        ph = lo || hi;
        if (t == 2 * W + 1 && m_rd) exp_rd = mw[m_off[18:2]];
        chk("m_ready", readyOut, t == 2 * W + 1);
        chk("m_addr", sramAddrOut, ph ? {m_off[18:2], hi} : 18'h0);
        chk("m_strobes", {ceN, oeN, weN, ubN, lbN}, {!ph, !(ph && m_rd), !(ph && !m_rd), !ph, !ph});
        chk("m_dqoe", sramDqOeOut, ph && !m_rd);
        chk("m_dq", sramDqOut, (ph && !m_rd) ? (lo ? m_dat[15:0] : m_dat[31:16]) : 16'h0);
        chk("m_rdata", readDataOut, exp_rd);
        t = (t == 2 * W + 1) ? -1 : t + 1;
      end
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    rdEnIn = rd; wrEnIn = wr; addressIn = a; writeDataIn = d;
  endtask

  task automatic drop();
    @(posedge clk);
    #1;
    rdEnIn = 0; wrEnIn = 0;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    int n;
    drive(rd, wr, a, d);
    n = 0;
    @(negedge clk);
    while (!readyOut && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 2 * W + 1);
    drop();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2 rst = 1;
    @(negedge clk);
    chk("t1_ready", readyOut, 1);
    chk("t1_strobes", {ceN, oeN, weN, ubN, lbN}, 5'h1f);
    chk("t1_dqoe", sramDqOeOut, 0);
    chk("t1_rdata", readDataOut, 0);

    drive(0, 1, 32'd1028, 32'hDEADBEEF);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t2_ready", readyOut, c == 7);
      if (c >= 1 && c <= 6) begin
        chk("t2_addr", sramAddrOut, c <= 3 ? 18'h00002 : 18'h00003);
        chk("t2_dq", sramDqOut, c <= 3 ? 16'hBEEF : 16'hDEAD);
        chk("t2_wen", weN, 0);
      end
    end
    drop();

    drive(1, 0, 32'd1028, 32'h0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t3_ready", readyOut, c == 7);
      if (c == 7) chk("t3_rdata", readDataOut, 32'hDEADBEEF);
    end
    drop();
    repeat (3) @(negedge clk);
    chk("t3_hold", readDataOut, 32'hDEADBEEF);

    drive(1, 1, 32'd1024, 32'h12345678);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t4_wen", weN, 1);
      chk("t4_oen", oeN, !(c >= 1 && c <= 6));
      if (c == 7) chk("t4_rdata", readDataOut, 32'h5A5B5A5A);
    end
    drop();

    drive(0, 1, 32'd1020, 32'h0BADF00D);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 6) chk("t6_addr", sramAddrOut, c <= 3 ? 18'h3FFFE : 18'h3FFFF);
    end
    drop();
    access(1, 0, 32'd1020, 32'h0);
    chk("t6_rdata", readDataOut, 32'h0BADF00D);

    access(0, 1, 32'd1100, 32'hCAFEF00D);
    access(1, 0, 32'd1102, 32'h0);
    chk("unaligned_rdata", readDataOut, 32'hCAFEF00D);
    access(1, 0, 32'd2000, 32'h0);
    access(0, 1, 32'd1028, 32'h76543210);
    access(1, 1, 32'd1028, 32'hFFFFFFFF);
    chk("rw_rdata", readDataOut, 32'h76543210);

    drive(0, 1, 32'd2048, 32'h11112222);
    for (int c = 0; c < 6; c++) @(negedge clk);
    #2 rst = 0;
    #1;
    chk("t5_strobes", {ceN, oeN, weN, ubN, lbN}, 5'h1f);
    chk("t5_dqoe", sramDqOeOut, 0);
    chk("t5_addr", sramAddrOut, 0);
    @(posedge clk);
    #1 wrEnIn = 0;
    @(negedge clk);
    #2 rst = 1;
    @(negedge clk);
    chk("t5_ready", readyOut, 1);
    chk("t5_rdata", readDataOut, 0);
    access(1, 0, 32'd1028, 32'h0);
    chk("t5_after", readDataOut, 32'h76543210);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
